// File: rtl/pingpong_aggregator.sv
// Serial-to-parallel packer with two alternating banks: one fills from the input
// stream while the other holds a completed vector until the consumer takes it.
module pingpong_aggregator #(
   parameter int               WIDTH  = 32,
   parameter int               N_OUTS = 4,
   parameter logic [WIDTH-1:0] PAD    = '0,
   localparam int              CW     = $clog2(N_OUTS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_OUTS*WIDTH-1:0]  out,
   output logic [CW-1:0]            out_count
);

   localparam int PW = (N_OUTS > 1) ? $clog2(N_OUTS) : 1;

   logic [WIDTH-1:0] bank_r [2][N_OUTS];
   logic [1:0]       full_r;
   logic [CW-1:0]    count_r [2];
   logic             wb_r;
   logic             rb_r;
   logic [PW-1:0]    wptr_r;

   logic             accept_s;
   logic             last_s;
   logic             close_s;
   logic             pop_s;
   logic [CW-1:0]    n_s;

   // in_ready depends only on registered state, never on out_ready or flush
   assign in_ready = !full_r[wb_r];

   // Handshake decode: n_s is the word count the write bank holds after this cycle
   always_comb begin
      accept_s = in_valid && in_ready;
      last_s   = (wptr_r == PW'(N_OUTS - 1));
      n_s      = CW'(wptr_r) + CW'(accept_s);
      pop_s    = full_r[rb_r] && out_ready;
      close_s  = 1'b0;
      if (in_ready) begin
         close_s = (accept_s && last_s) || (flush && (n_s != {CW{1'b0}}));
      end else begin
         close_s = 1'b0;
      end
   end

   // Bank storage, fill pointer and per-bank full/count bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N_OUTS; i++) begin
               bank_r[b][i] <= {WIDTH{1'b0}};
            end
            count_r[b] <= {CW{1'b0}};
         end
         full_r <= 2'b00;
         wb_r   <= 1'b0;
         rb_r   <= 1'b0;
         wptr_r <= {PW{1'b0}};
      end else begin
         // Slots at or beyond the final count are padded when a vector closes
         for (int i = 0; i < N_OUTS; i++) begin
            if (accept_s && (PW'(i) == wptr_r)) begin
               bank_r[wb_r][i] <= in;
            end else if (close_s && (CW'(i) >= n_s)) begin
               bank_r[wb_r][i] <= PAD;
            end
         end
         if (close_s) begin
            full_r[wb_r]  <= 1'b1;
            count_r[wb_r] <= n_s;
            wb_r          <= !wb_r;
            wptr_r        <= {PW{1'b0}};
         end else if (accept_s) begin
            wptr_r <= wptr_r + PW'(1);
         end
         // A pop always targets the other bank than a close, since close needs !full[wb]
         if (pop_s) begin
            full_r[rb_r] <= 1'b0;
            rb_r         <= !rb_r;
         end
      end
   end

   // Present the read bank as one packed vector
   always_comb begin
      out = {(N_OUTS*WIDTH){1'b0}};
      for (int i = 0; i < N_OUTS; i++) begin
         out[i*WIDTH +: WIDTH] = bank_r[rb_r][i];
      end
      out_valid = full_r[rb_r];
      if (full_r[rb_r]) begin
         out_count = count_r[rb_r];
      end else begin
         out_count = {CW{1'b0}};
      end
   end

endmodule

// File: tb/tb_pingpong_aggregator.sv
// Scoreboard bench for pingpong_aggregator (WIDTH=8, N_OUTS=4, PAD=0xEE): directed
// stimulus pushes hand-computed vectors; a negedge monitor pops them on each transfer.
module tb_pingpong_aggregator;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic [2:0]  out_count;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   pingpong_aggregator #(.WIDTH(8), .N_OUTS(4), .PAD(8'hEE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [2:0] c);
      exp_t e;
      e.data = d;
      e.cnt  = c;
      sb.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic f);
      @(posedge clk);
      #1;
      in_valid = v;
      in       = d;
      flush    = f;
   endtask

   // Present a word and hold it until in_ready shows it will be taken at the next edge
   task automatic send_wait(input logic [7:0] d);
      int guard;
      drive(1'b1, d, 1'b0);
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: every transfer must match the oldest expected vector
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_vector: got %h count %0d, expected none", out, out_count);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("vec_data", out, e.data);
            check("vec_count", 32'(out_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk       = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in        = 8'h00;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_out", out, 32'h0);

      // Basic packing with a ready consumer
      out_ready = 1'b1;
      push(32'h44332211, 3'd4);
      send_wait(8'h11);
      send_wait(8'h22);
      send_wait(8'h33);
      send_wait(8'h44);
      drive(1'b0, 8'h00, 1'b0);
      check("t1_valid_next", 32'(out_valid), 32'd1);
      repeat (4) drive(1'b0, 8'h00, 1'b0);
      check("t1_drained", 32'(sb.size()), 32'd0);

      // Back-pressure: both banks fill, flush is ignored while stalled
      out_ready = 1'b0;
      push(32'h04030201, 3'd4);
      push(32'h08070605, 3'd4);
      push(32'h0C0B0A09, 3'd4);
      for (int k = 1; k <= 8; k++) send_wait(8'(k));
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'h09, 1'b1);
         check("bp_in_ready_low", 32'(in_ready), 32'd0);
         check("bp_stable_out", out, 32'h04030201);
         check("bp_stable_count", 32'(out_count), 32'd4);
      end
      drive(1'b1, 8'h09, 1'b0);
      out_ready = 1'b1;
      check("bp_no_comb_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_ready_after_pop", 32'(in_ready), 32'd1);
      for (int k = 10; k <= 12; k++) send_wait(8'(k));
      drive(1'b0, 8'h00, 1'b0);
      out_ready = 1'b1;
      repeat (5) drive(1'b0, 8'h00, 1'b0);
      check("bp_drained", 32'(sb.size()), 32'd0);

      // Flush: alone, together with an accept, and with an empty write bank
      push(32'hEEEEA2A1, 3'd2);
      send_wait(8'hA1);
      send_wait(8'hA2);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      push(32'hEEA3A2A1, 3'd3);
      send_wait(8'hA1);
      send_wait(8'hA2);
      drive(1'b1, 8'hA3, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      repeat (2) drive(1'b0, 8'h00, 1'b0);
      repeat (3) drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      check("fl_empty_no_vec", 32'(out_valid), 32'd0);
      repeat (2) drive(1'b0, 8'h00, 1'b0);
      check("fl_drained", 32'(sb.size()), 32'd0);

      // Reset mid-vector with one bank pending
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) send_wait(8'h51 + 8'(k));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mr_out_valid", 32'(out_valid), 32'd0);
      check("mr_in_ready", 32'(in_ready), 32'd1);
      check("mr_out_count", 32'(out_count), 32'd0);
      check("mr_out", out, 32'h0);
      out_ready = 1'b1;
      push(32'h24232221, 3'd4);
      for (int k = 0; k < 4; k++) send_wait(8'h21 + 8'(k));
      repeat (4) drive(1'b0, 8'h00, 1'b0);
      check("mr_drained", 32'(sb.size()), 32'd0);

      // Pop of bank0 in the same cycle bank1 receives its last word
      do_reset();
      out_ready = 1'b0;
      push(32'h34333231, 3'd4);
      push(32'h38373635, 3'd4);
      for (int k = 0; k < 7; k++) send_wait(8'h31 + 8'(k));
      drive(1'b1, 8'h38, 1'b0);
      out_ready = 1'b1;
      check("sp_ready_before", 32'(in_ready), 32'd1);
      drive(1'b0, 8'h00, 1'b0);
      check("sp_ready_after", 32'(in_ready), 32'd1);
      check("sp_valid_next", 32'(out_valid), 32'd1);
      check("sp_count_next", 32'(out_count), 32'd4);
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      check("sp_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pingpong_aggregator.md
# pingpong_aggregator

Serial-to-parallel packer: accepts one WIDTH-bit word per cycle over a valid/ready handshake and emits N_OUTS words as one packed vector over a second valid/ready handshake. Two internal banks alternate (ping-pong), so input keeps flowing while a completed vector waits for the consumer. A flush request closes a partially filled vector early, pads it, and reports its word count. It sits between a streaming producer and wide consumers such as single_port_sram write ports or parallel datapaths.

## Interface
- WIDTH, 32, bits per input word (>=1)
- N_OUTS, 4, words per output vector (>=1)
- PAD, 0, WIDTH-bit fill value for unwritten slots of a flushed vector
- CW (localparam), $clog2(N_OUTS+1), width of out_count
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  producer has a word
- in_ready  out  1  aggregator can accept a word this cycle
- in  in  WIDTH  input word
- flush  in  1  close the current partial vector
- out_valid  out  1  packed vector available
- out_ready  in  1  consumer takes vector this cycle
- out  out  N_OUTS*WIDTH  packed vector, word i at out[i*WIDTH +: WIDTH]
- out_count  out  CW  number of real words in out (1..N_OUTS), 0 when out_valid=0

## Operation
- State: bank data [2][N_OUTS], per-bank full flag and count, write-bank index wb, read-bank index rb, write pointer wptr (0..N_OUTS-1).
- in_ready = !full[wb]. It is registered state only: no combinational path from out_ready or flush to in_ready.
- Accept (in_valid & in_ready): bank[wb][wptr] <= in. If wptr == N_OUTS-1: full[wb] <= 1, count[wb] <= N_OUTS, wb toggles, wptr <= 0. Otherwise wptr increments.
- Flush is sampled only when in_ready=1; it is ignored (not remembered) when in_ready=0. Let n = wptr + (accept ? 1 : 0).
  - n == 0: no-op.
  - 0 < n < N_OUTS: slots n..N_OUTS-1 of bank[wb] <= PAD; full[wb] <= 1, count[wb] <= n; wb toggles; wptr <= 0.
  - n == N_OUTS: identical to a normal completing accept (flush is redundant).
- Output: out_valid = full[rb]; out = bank[rb]; out_count = full[rb] ? count[rb] : 0.
- Pop (out_valid & out_ready): full[rb] <= 0, rb toggles. Bank data is not cleared.
- Pop and a completing accept/flush in the same cycle touch different banks and both take effect.
- out and bank contents while out_valid=0 are don't-care except after reset.

## Timing
- Reset (rst=1 at a posedge): wb=rb=0, wptr=0, both full=0, all bank data 0. Outputs afterward: in_ready=1, out_valid=0, out_count=0, out=0. rst overrides accept, flush and pop in the same cycle. Any partial vector is discarded.
- Latency: the cycle that accepts the last word of a vector, or the flush cycle, is cycle t. out_valid=1 from cycle t+1.
- Throughput: 1 word/cycle sustained when each vector is popped within N_OUTS cycles of becoming valid.
- Back-pressure: when both banks are full, in_ready=0. A pop at cycle t raises in_ready at t+1, not at t.
- out and out_count are stable while out_valid=1 and out_ready=0.
- N_OUTS=1: every accept closes a vector and flush is always a no-op. Width of wptr is max(1, $clog2(N_OUTS)).

## Test plan
- WIDTH=8, N_OUTS=4, out_ready=1: stream 0x11,0x22,0x33,0x44 on consecutive cycles. Required: one cycle after the 4th accept, out=0x44332211, out_count=4, out_valid=1 for exactly one cycle.
- out_ready=0: stream 12 words. Required: first 8 words accepted, in_ready=0 from the cycle after the 8th accept. After one pop, in_ready=1 on the next cycle. Vectors pop in order 0x04030201, 0x08070605, then 0x0C0B0A09.
- PAD=0xEE: accept 0xA1,0xA2, then flush alone. Required: out=0xEEEEA2A1, out_count=2. Flush together with the accept of 0xA3 after 0xA1,0xA2 gives 0xEEA3A2A1, count 3. Flush with wptr=0 and no accept produces nothing.
- Flush while both banks are full: it is ignored, and no vector appears beyond the two already pending.
- Assert rst mid-vector after 2 accepts and with one full bank pending. Required: next cycle out_valid=0, in_ready=1, out_count=0. The next 4 words form 0x..., starting at slot 0.
- Simultaneous pop and completing accept, with bank0 full and bank1 receiving its 4th word while out_ready=1. Required: bank0 pops, bank1 out_valid on the next cycle, and in_ready stays 1 throughout.
